// File: rtl/bcd_to_bin_serial_if.sv
// Handshake/data bundle between a digit-entry source and bcd_to_bin_serial.
//   master : drives start/bcd_in, observes busy/done/bin_out/err
//   slave  : the converter side
interface bcd_to_bin_serial_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (output start, bcd_in, input  busy, done, bin_out, err);
    modport slave  (input  start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd_to_bin_serial.sv
// Sequential BCD-to-binary converter using reverse double-dabble: one
// shift/correct step per clock, BIN_W steps per conversion.
// Ports:
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   bus     : slave side of bcd_to_bin_serial_if
//             start/bcd_in in; busy/done/bin_out/err out
// A start seen in IDLE captures bcd_in. An operand with any digit > 9 skips
// the conversion and reports err one edge later with bin_out = 0.
module bcd_to_bin_serial #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  resetn,
    bcd_to_bin_serial_if.slave    bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [BCD_W-1:0]    bcd_sr_q, bcd_sr_d;
    logic [BIN_W-1:0]    bin_sr_q, bin_sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_out_q, bin_out_d;
    logic                err_q, err_d;

    logic                bad_digit;
    logic [BCD_W-1:0]    bcd_step;
    logic [BIN_W-1:0]    bin_step;

    // One reverse double-dabble step: the BCD LSB falls into the binary
    // register from the top, then every digit that now reads >= 8 had a
    // borrowed '1' from its neighbour worth 8 instead of 5, so subtract 3.
    always_comb begin
        bcd_step = bcd_sr_q >> 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_step[4*d +: 4] >= 4'd8)
                bcd_step[4*d +: 4] = bcd_step[4*d +: 4] - 4'd3;
        end
        bin_step = {bcd_sr_q[0], bin_sr_q[BIN_W-1:1]};
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bus.bcd_in[4*d +: 4] > 4'd9)
                bad_digit = 1'b1;
        end
    end

    // Next-state and datapath. bin_out/err only move on the edge entering
    // DONE so the previous result stays visible throughout a conversion.
    always_comb begin
        state_d   = state_q;
        bcd_sr_d  = bcd_sr_q;
        bin_sr_d  = bin_sr_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    bcd_sr_d = bus.bcd_in;
                    bin_sr_d = '0;
                    cnt_d    = '0;
                    if (bad_digit) begin
                        err_d     = 1'b1;
                        bin_out_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_CONV;
                    end
                end
            end
            S_CONV: begin
                bcd_sr_d = bcd_step;
                bin_sr_d = bin_step;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    bin_out_d = bin_step;
                    err_d     = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            bcd_sr_q  <= '0;
            bin_sr_q  <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_sr_q  <= bcd_sr_d;
            bin_sr_q  <= bin_sr_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end

    assign bus.busy    = (state_q == S_CONV);
    assign bus.done    = (state_q == S_DONE);
    assign bus.bin_out = bin_out_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Directed bench for bcd_to_bin_serial (DIGITS=2, BIN_W=7).
module tb_bcd_to_bin_serial;
    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    bcd_to_bin_serial_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bif ();

    bcd_to_bin_serial #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One start pulse, then bcd_in is scrambled to show it is not re-sampled.
    task automatic conv(input string tag, input logic [7:0] v,
                        input logic [6:0] eb, input logic ee);
        int lat;
        int nb;
        @(negedge clk);
        bif.start  = 1'b1;
        bif.bcd_in = v;
        @(negedge clk);
        bif.start  = 1'b0;
        bif.bcd_in = ~v;
        lat = 1;
        nb  = 0;
        while (!bif.done && lat < 20) begin
            if (bif.busy) nb++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},  lat, ee ? 1 : BIN_W + 1);
        chk({tag, "_busy"}, nb,  ee ? 0 : BIN_W);
        chk({tag, "_bin"},  bif.bin_out, eb);
        chk({tag, "_err"},  bif.err, ee);
        @(negedge clk);
        chk({tag, "_pulse"}, bif.done, 0);
    endtask

    initial begin
        int ndone;
        int t[$];
        logic [6:0] cap;
        bif.start  = 1'b0;
        bif.bcd_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bif.busy, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_err",  bif.err, 0);
        chk("rst_bin",  bif.bin_out, 0);
        resetn = 1'b1;

        // basic values
        conv("c99", 8'h99, 7'd99, 1'b0);
        conv("c00", 8'h00, 7'd0,  1'b0);
        conv("c47", 8'h47, 7'd47, 1'b0);
        conv("c10", 8'h10, 7'd10, 1'b0);

        // invalid digits, then recovery
        conv("c3A", 8'h3A, 7'd0, 1'b1);
        conv("c05", 8'h05, 7'd5, 1'b0);
        conv("cA0", 8'hA0, 7'd0, 1'b1);
        conv("cFF", 8'hFF, 7'd0, 1'b1);
        conv("c80", 8'h80, 7'd80, 1'b0);

        // start during CONV is ignored
        @(negedge clk);
        bif.start = 1'b1; bif.bcd_in = 8'h25;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (2) @(negedge clk);
        bif.start = 1'b1; bif.bcd_in = 8'h88;
        @(negedge clk);
        bif.start = 1'b0;
        ndone = 0; cap = '0;
        for (int i = 0; i < 25; i++) begin
            if (bif.done) begin ndone++; cap = bif.bin_out; end
            @(negedge clk);
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_bin",   cap, 25);

        // async reset mid-conversion
        @(negedge clk);
        bif.start = 1'b1; bif.bcd_in = 8'h63;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", bif.busy, 1);
        resetn = 1'b0;
        #1;
        chk("arst_busy", bif.busy, 0);
        chk("arst_done", bif.done, 0);
        chk("arst_bin",  bif.bin_out, 0);
        chk("arst_err",  bif.err, 0);
        @(negedge clk);
        resetn = 1'b1;
        conv("c12", 8'h12, 7'd12, 1'b0);

        // start held high: back-to-back conversions
        @(negedge clk);
        bif.start = 1'b1; bif.bcd_in = 8'h50;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bif.done) begin
                t.push_back(i);
                chk("hold_bin", bif.bin_out, 50);
            end
        end
        bif.start = 1'b0;
        chk("hold_cnt", (t.size() >= 3) ? 1 : 0, 1);
        if (t.size() >= 3) begin
            chk("hold_per0", t[1] - t[0], BIN_W + 2);
            chk("hold_per1", t[2] - t[1], BIN_W + 2);
        end
        repeat (12) @(negedge clk);

        // exhaustive valid sweep against the decimal value
        for (int hi = 0; hi < 10; hi++) begin
            for (int lo = 0; lo < 10; lo++) begin
                logic [3:0] h4, l4;
                h4 = 4'(hi);
                l4 = 4'(lo);
                conv($sformatf("sw%0d%0d", hi, lo), {h4, l4}, 7'(hi * 10 + lo), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
